// File: rtl/mem_fill_arbiter.sv
// mem_fill_arbiter
// Shares one pipelined single-port memory between I-cache fills, D-cache fills
// and D-cache write-through stores. A fill is a burst of WORDS back-to-back reads
// of one aligned block. Each returned word is steered to the cache that owns the
// fill, tagged with its index within the block. The owner sees a done pulse
// together with the last word.
`timescale 1ns/1ps

module mem_fill_arbiter #(
    parameter int ADDR_W  = 16,
    parameter int DATA_W  = 16,
    parameter int WORDS   = 8,
    parameter int MEM_LAT = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       i_miss,
    input  logic [ADDR_W-1:0]          i_addr,
    input  logic                       d_miss,
    input  logic [ADDR_W-1:0]          d_addr,
    input  logic                       d_wr,
    input  logic [DATA_W-1:0]          d_wdata,
    output logic                       mem_en,
    output logic                       mem_wr,
    output logic [ADDR_W-1:0]          mem_addr,
    output logic [DATA_W-1:0]          mem_wdata,
    input  logic [DATA_W-1:0]          mem_rdata,
    input  logic                       mem_rdata_valid,
    output logic [DATA_W-1:0]          fill_data,
    output logic [$clog2(WORDS)-1:0]   fill_word,
    output logic                       i_fill_we,
    output logic                       d_fill_we,
    output logic                       i_fill_done,
    output logic                       d_fill_done,
    output logic                       d_wr_done,
    output logic                       busy
);

    localparam int CW = $clog2(WORDS);      // word-index width
    localparam int NW = CW + 1;             // counter width, reaches WORDS without wrap
    localparam logic [NW-1:0]     LAST_CNT  = NW'(WORDS - 1);
    localparam logic [NW-1:0]     FULL_CNT  = NW'(WORDS);
    localparam logic [ADDR_W-1:0] BLK_MASK  = ~(ADDR_W'(2 * WORDS - 1));

    // Elaboration-time parameter sanity: block size must be a power of two and
    // the memory must have at least one cycle of read latency.
    if ((WORDS < 2) || ((WORDS & (WORDS - 1)) != 0) || (MEM_LAT < 1)) begin : g_param_check
        $error("mem_fill_arbiter: unsupported WORDS/MEM_LAT");
    end

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WRITE = 2'd1,
        ST_ISSUE = 2'd2,
        ST_DRAIN = 2'd3
    } state_e;

    state_e              state_q;
    logic                owner_d_q;     // 1 = D-cache owns the fill, 0 = I-cache
    logic [ADDR_W-1:0]   base_q;        // block-aligned fill address
    logic [NW-1:0]       iss_cnt_q;     // reads issued so far
    logic [NW-1:0]       ret_cnt_q;     // words returned so far

    logic                in_fill_s;
    logic                ret_fire_s;
    logic                ret_last_s;
    logic [ADDR_W-1:0]   iss_addr_s;

    // Return bookkeeping: a valid only counts while a fill is outstanding.
    always_comb begin
        in_fill_s  = (state_q == ST_ISSUE) || (state_q == ST_DRAIN);
        ret_fire_s = in_fill_s && mem_rdata_valid && (ret_cnt_q != FULL_CNT);
        ret_last_s = (ret_cnt_q == LAST_CNT);
        iss_addr_s = base_q + (ADDR_W'(iss_cnt_q[CW-1:0]) << 1);
    end

    // Arbitration FSM with issue/return counters and fill ownership.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            owner_d_q <= 1'b0;
            base_q    <= {ADDR_W{1'b0}};
            iss_cnt_q <= {NW{1'b0}};
            ret_cnt_q <= {NW{1'b0}};
        end else begin
            case (state_q)
                ST_IDLE: begin
                    iss_cnt_q <= {NW{1'b0}};
                    ret_cnt_q <= {NW{1'b0}};
                    if (d_wr) begin
                        state_q <= ST_WRITE;
                    end else if (d_miss) begin
                        state_q   <= ST_ISSUE;
                        owner_d_q <= 1'b1;
                        base_q    <= d_addr & BLK_MASK;
                    end else if (i_miss) begin
                        state_q   <= ST_ISSUE;
                        owner_d_q <= 1'b0;
                        base_q    <= i_addr & BLK_MASK;
                    end else begin
                        state_q <= ST_IDLE;
                    end
                end
                ST_WRITE: begin
                    state_q <= ST_IDLE;
                end
                ST_ISSUE: begin
                    iss_cnt_q <= iss_cnt_q + NW'(1);
                    if (ret_fire_s) begin
                        ret_cnt_q <= ret_cnt_q + NW'(1);
                    end
                    if (iss_cnt_q == LAST_CNT) begin
                        state_q <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (ret_fire_s) begin
                        ret_cnt_q <= ret_cnt_q + NW'(1);
                    end
                    if ((ret_fire_s && ret_last_s) || (ret_cnt_q == FULL_CNT)) begin
                        state_q <= ST_IDLE;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    // Memory-side and cache-side outputs decoded from state, counters and returns.
    always_comb begin
        mem_en      = 1'b0;
        mem_wr      = 1'b0;
        mem_addr    = {ADDR_W{1'b0}};
        mem_wdata   = {DATA_W{1'b0}};
        fill_data   = {DATA_W{1'b0}};
        fill_word   = {CW{1'b0}};
        i_fill_we   = 1'b0;
        d_fill_we   = 1'b0;
        i_fill_done = 1'b0;
        d_fill_done = 1'b0;
        d_wr_done   = 1'b0;
        busy        = (state_q != ST_IDLE);
        case (state_q)
            ST_WRITE: begin
                mem_en    = 1'b1;
                mem_wr    = 1'b1;
                mem_addr  = d_addr;
                mem_wdata = d_wdata;
                d_wr_done = 1'b1;
            end
            ST_ISSUE: begin
                mem_en   = 1'b1;
                mem_addr = iss_addr_s;
            end
            default: begin
                mem_en = 1'b0;
            end
        endcase
        if (ret_fire_s) begin
            fill_data   = mem_rdata;
            fill_word   = ret_cnt_q[CW-1:0];
            i_fill_we   = !owner_d_q;
            d_fill_we   = owner_d_q;
            i_fill_done = !owner_d_q && ret_last_s;
            d_fill_done = owner_d_q && ret_last_s;
        end else begin
            fill_word = {CW{1'b0}};
        end
    end

endmodule

// File: tb/tb_mem_fill_arbiter.sv
// Self-checking bench for mem_fill_arbiter: per-cycle vector table for a plain
// I fill, then hand-written sequences for arbitration, writes, reset and stalls.
`timescale 1ns/1ps

module tb_mem_fill_arbiter;

    localparam int AW = 16;
    localparam int DW = 16;
    localparam int WORDS = 8;
    localparam int MEM_LAT = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          i_miss = 1'b0;
    logic [AW-1:0] i_addr = 16'h0000;
    logic          d_miss = 1'b0;
    logic [AW-1:0] d_addr = 16'h0000;
    logic          d_wr = 1'b0;
    logic [DW-1:0] d_wdata = 16'h0000;
    logic          mem_en, mem_wr;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata = 16'h0000;
    logic          mem_rdata_valid = 1'b0;
    logic [DW-1:0] fill_data;
    logic [2:0]    fill_word;
    logic          i_fill_we, d_fill_we, i_fill_done, d_fill_done, d_wr_done, busy;

    mem_fill_arbiter #(.ADDR_W(AW), .DATA_W(DW), .WORDS(WORDS), .MEM_LAT(MEM_LAT)) dut (
        .clk(clk), .rst_n(rst_n),
        .i_miss(i_miss), .i_addr(i_addr),
        .d_miss(d_miss), .d_addr(d_addr),
        .d_wr(d_wr), .d_wdata(d_wdata),
        .mem_en(mem_en), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_rdata_valid(mem_rdata_valid),
        .fill_data(fill_data), .fill_word(fill_word),
        .i_fill_we(i_fill_we), .d_fill_we(d_fill_we),
        .i_fill_done(i_fill_done), .d_fill_done(d_fill_done),
        .d_wr_done(d_wr_done), .busy(busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    // Memory contents model: data is a fixed function of the byte address.
    function automatic logic [15:0] mdata(input logic [15:0] a);
        return a ^ 16'hA5A5;
    endfunction

    // Packs the expected/actual output set into one comparable vector.
    function automatic logic [58:0] pk(input logic en, input logic wr, input logic [15:0] addr,
                                       input logic [15:0] wdata, input logic [15:0] fdata,
                                       input logic [2:0] fword, input logic iwe, input logic dwe,
                                       input logic idone, input logic ddone, input logic wdone,
                                       input logic bsy);
        return {en, wr, addr, wdata, fdata, fword, iwe, dwe, idone, ddone, wdone, bsy};
    endfunction

    function automatic logic [58:0] outs();
        return pk(mem_en, mem_wr, mem_addr, mem_wdata, fill_data, fill_word, i_fill_we,
                  d_fill_we, i_fill_done, d_fill_done, d_wr_done, busy);
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Pipelined memory model: MEM_LAT latency, optional stall pattern on returns.
    int            due_q[$];
    logic [15:0]   adr_q[$];
    bit            stall_mode = 1'b0;

    always @(negedge clk) begin
        if (mem_en && !mem_wr) begin
            due_q.push_back(cyc + MEM_LAT);
            adr_q.push_back(mem_addr);
        end
    end

    always @(posedge clk) begin
        #1;
        mem_rdata_valid = 1'b0;
        mem_rdata       = 16'h0000;
        if (due_q.size() > 0 && due_q[0] <= cyc && !(stall_mode && (cyc % 3) != 0)) begin
            mem_rdata_valid = 1'b1;
            mem_rdata       = mdata(adr_q[0]);
            void'(due_q.pop_front());
            void'(adr_q.pop_front());
        end
    end

    // Event logs gathered at the falling edge.
    typedef struct {
        bit          own_d;
        int          word;
        logic [15:0] data;
        int          c;
    } fill_t;

    fill_t       fill_log[$];
    int          rd_cyc[$];
    logic [15:0] rd_addr[$];
    int          wr_cyc[$];
    logic [15:0] wr_addr[$];
    logic [15:0] wr_data[$];
    int          idone_c[$];
    int          ddone_c[$];
    int          wdone_c[$];
    int          both_we = 0;

    always @(negedge clk) begin
        if (mem_en && mem_wr) begin
            wr_cyc.push_back(cyc); wr_addr.push_back(mem_addr); wr_data.push_back(mem_wdata);
        end
        if (mem_en && !mem_wr) begin
            rd_cyc.push_back(cyc); rd_addr.push_back(mem_addr);
        end
        if (i_fill_we) fill_log.push_back('{1'b0, int'(fill_word), fill_data, cyc});
        if (d_fill_we) fill_log.push_back('{1'b1, int'(fill_word), fill_data, cyc});
        if (i_fill_we && d_fill_we) both_we++;
        if (i_fill_done) idone_c.push_back(cyc);
        if (d_fill_done) ddone_c.push_back(cyc);
        if (d_wr_done) wdone_c.push_back(cyc);
    end

    task automatic clear_logs();
        fill_log.delete(); rd_cyc.delete(); rd_addr.delete();
        wr_cyc.delete(); wr_addr.delete(); wr_data.delete();
        idone_c.delete(); ddone_c.delete(); wdone_c.delete();
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Acts as the requesting caches: each request drops the cycle after its done.
    task automatic run_until_idle(input string name, input int budget);
        int  n;
        bit  di, dd, dw;
        n = 0;
        while ((i_miss || d_miss || d_wr || busy) && n < budget) begin
            @(negedge clk);
            di = i_fill_done; dd = d_fill_done; dw = d_wr_done;
            step();
            if (di) i_miss = 1'b0;
            if (dd) d_miss = 1'b0;
            if (dw) d_wr = 1'b0;
            n++;
        end
        chk({name, "_budget"}, 64'(n < budget), 64'd1);
    endtask

    // Verifies eight consecutive fill log entries against the memory model.
    task automatic check_fill(input string name, input bit own_d, input logic [15:0] base,
                              input int idx0);
        chk({name, "_count"}, 64'(fill_log.size() >= idx0 + WORDS), 64'd1);
        if (fill_log.size() >= idx0 + WORDS) begin
            for (int w = 0; w < WORDS; w++) begin
                chk($sformatf("%s_w%0d", name, w),
                    {fill_log[idx0+w].own_d, 8'(fill_log[idx0+w].word), fill_log[idx0+w].data},
                    {own_d, 8'(w), mdata(base + 16'(2 * w))});
            end
        end
    endtask

    typedef struct {
        logic        i_miss;
        logic [15:0] i_addr;
        logic [58:0] exp;
    } vec_t;

    vec_t vecs[14];
    int   t0;

    initial begin
        // Per-cycle vectors: I miss at 0x1236, reads 0x1230..0x123E in cycles 1-8,
        // words 0-7 return in cycles 5-12, done with the last word, idle at 13.
        vecs[0]  = '{1'b1, 16'h1236, pk(0, 0, 16'h0000, 0, 16'h0000,            3'd0, 0, 0, 0, 0, 0, 0)};
        vecs[1]  = '{1'b1, 16'h1236, pk(1, 0, 16'h1230, 0, 16'h0000,            3'd0, 0, 0, 0, 0, 0, 1)};
        vecs[2]  = '{1'b1, 16'h1236, pk(1, 0, 16'h1232, 0, 16'h0000,            3'd0, 0, 0, 0, 0, 0, 1)};
        vecs[3]  = '{1'b1, 16'h1236, pk(1, 0, 16'h1234, 0, 16'h0000,            3'd0, 0, 0, 0, 0, 0, 1)};
        vecs[4]  = '{1'b1, 16'h1236, pk(1, 0, 16'h1236, 0, 16'h0000,            3'd0, 0, 0, 0, 0, 0, 1)};
        vecs[5]  = '{1'b1, 16'h1236, pk(1, 0, 16'h1238, 0, mdata(16'h1230),     3'd0, 1, 0, 0, 0, 0, 1)};
        vecs[6]  = '{1'b1, 16'h1236, pk(1, 0, 16'h123A, 0, mdata(16'h1232),     3'd1, 1, 0, 0, 0, 0, 1)};
        vecs[7]  = '{1'b1, 16'h1236, pk(1, 0, 16'h123C, 0, mdata(16'h1234),     3'd2, 1, 0, 0, 0, 0, 1)};
        vecs[8]  = '{1'b1, 16'h1236, pk(1, 0, 16'h123E, 0, mdata(16'h1236),     3'd3, 1, 0, 0, 0, 0, 1)};
        vecs[9]  = '{1'b1, 16'h1236, pk(0, 0, 16'h0000, 0, mdata(16'h1238),     3'd4, 1, 0, 0, 0, 0, 1)};
        vecs[10] = '{1'b1, 16'h1236, pk(0, 0, 16'h0000, 0, mdata(16'h123A),     3'd5, 1, 0, 0, 0, 0, 1)};
        vecs[11] = '{1'b1, 16'h1236, pk(0, 0, 16'h0000, 0, mdata(16'h123C),     3'd6, 1, 0, 0, 0, 0, 1)};
        vecs[12] = '{1'b1, 16'h1236, pk(0, 0, 16'h0000, 0, mdata(16'h123E),     3'd7, 1, 0, 1, 0, 0, 1)};
        vecs[13] = '{1'b0, 16'h1236, pk(0, 0, 16'h0000, 0, 16'h0000,            3'd0, 0, 0, 0, 0, 0, 0)};

        // Reset state
        repeat (3) @(negedge clk);
        chk("reset_outs", 64'(outs()), 64'd0);
        step();
        rst_n = 1'b1;
        repeat (2) step();

        // Vector table: plain I-cache fill
        for (int k = 0; k < 14; k++) begin
            if (k > 0) step();
            i_miss = vecs[k].i_miss;
            i_addr = vecs[k].i_addr;
            @(negedge clk);
            chk($sformatf("vec%0d", k), 64'(outs()), 64'(vecs[k].exp));
        end
        repeat (3) step();

        // Simultaneous I and D miss: D served first, I granted right after
        clear_logs();
        i_miss = 1'b1; i_addr = 16'h1236; d_miss = 1'b1; d_addr = 16'h4008;
        run_until_idle("prio", 100);
        chk("prio_nfill", 64'(fill_log.size()), 64'd16);
        check_fill("prio_d", 1'b1, 16'h4000, 0);
        check_fill("prio_i", 1'b0, 16'h1230, 8);
        chk("prio_done_counts", {32'(ddone_c.size()), 32'(idone_c.size())}, {32'd1, 32'd1});
        if (ddone_c.size() == 1 && rd_cyc.size() == 16) begin
            chk("prio_d_latency", 64'(ddone_c[0] - rd_cyc[0]), 64'd11);
            chk("prio_i_start", 64'(rd_cyc[8]), 64'(ddone_c[0] + 2));
            chk("prio_i_addr", 64'(rd_addr[8]), 64'h1230);
        end else begin
            chk("prio_reads", 64'(rd_cyc.size()), 64'd16);
        end
        repeat (3) step();

        // Write-through beats a D miss; the fill follows the write
        clear_logs();
        t0 = cyc;
        d_wr = 1'b1; d_miss = 1'b1; d_addr = 16'h2002; d_wdata = 16'hBEEF;
        run_until_idle("wr", 100);
        chk("wr_count", 64'(wr_cyc.size()), 64'd1);
        if (wr_cyc.size() == 1) begin
            chk("wr_beat", {32'(wr_cyc[0] - t0), wr_addr[0], wr_data[0]},
                {32'd1, 16'h2002, 16'hBEEF});
        end
        chk("wr_done", 64'(wdone_c.size() == 1 && wdone_c[0] == t0 + 1), 64'd1);
        chk("wr_fill_start", 64'(rd_cyc.size() > 0 && rd_cyc[0] == t0 + 3 && rd_addr[0] == 16'h2000), 64'd1);
        check_fill("wr_fill", 1'b1, 16'h2000, 0);
        chk("wr_no_i", 64'(idone_c.size()), 64'd0);
        repeat (3) step();

        // Write request arriving mid-fill waits for the fill to finish
        clear_logs();
        i_miss = 1'b1; i_addr = 16'h0ABC;
        repeat (3) step();
        d_wr = 1'b1; d_addr = 16'h7770; d_wdata = 16'h1234;
        run_until_idle("late_wr", 100);
        check_fill("late_wr_fill", 1'b0, 16'h0AB0, 0);
        chk("late_wr_count", 64'(wr_cyc.size()), 64'd1);
        if (wr_cyc.size() == 1 && idone_c.size() == 1) begin
            chk("late_wr_after", 64'(wr_cyc[0] - idone_c[0]), 64'd2);
            chk("late_wr_beat", {wr_addr[0], wr_data[0]}, {16'h7770, 16'h1234});
        end else begin
            chk("late_wr_idone", 64'(idone_c.size()), 64'd1);
        end
        repeat (3) step();

        // Reset in the middle of a fill; stray returns afterwards are ignored
        clear_logs();
        i_miss = 1'b1; i_addr = 16'h1236;
        repeat (6) step();
        rst_n = 1'b0; i_miss = 1'b0;
        #1;
        chk("rst_async", 64'(outs()), 64'd0);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk($sformatf("rst_quiet%0d", k), 64'(outs()), 64'd0);
            step();
            if (k == 1) rst_n = 1'b1;
        end
        chk("rst_stray_we", 64'(fill_log.size()), 64'd1);
        clear_logs();
        d_miss = 1'b1; d_addr = 16'h3010;
        run_until_idle("post_rst", 100);
        check_fill("post_rst_fill", 1'b1, 16'h3010, 0);
        chk("post_rst_done", 64'(ddone_c.size()), 64'd1);
        repeat (3) step();

        // Gapped returns from a stalling memory
        clear_logs();
        stall_mode = 1'b1;
        i_miss = 1'b1; i_addr = 16'h555E;
        run_until_idle("stall", 200);
        stall_mode = 1'b0;
        chk("stall_nfill", 64'(fill_log.size()), 64'd8);
        check_fill("stall_fill", 1'b0, 16'h5550, 0);
        chk("stall_done_count", 64'(idone_c.size()), 64'd1);
        if (idone_c.size() == 1 && fill_log.size() == 8 && rd_cyc.size() > 0) begin
            chk("stall_done_last", 64'(idone_c[0]), 64'(fill_log[7].c));
            chk("stall_gapped", 64'(fill_log[7].c > rd_cyc[0] + 11), 64'd1);
        end

        chk("never_both_we", 64'(both_we), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Absolute time limit so the bench can never hang.
    initial begin
        #200000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

endmodule
